// File: rtl/entry_search_bank.sv
// ============================================================================
//  Module      : entry_search_bank
//  Description : 32 x 13-bit storage bank with a sequential linear-search
//                engine that drives an external 32:1 mux and reads it back.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module entry_search_bank #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clear,
  output logic [DEPTH*WIDTH-1:0] entries_flat,
  output logic [AW-1:0]          scan_select,
  input  logic [WIDTH-1:0]       scan_data,
  input  logic                   start,
  input  logic [WIDTH-1:0]       key,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [AW-1:0]          match_index,
  output logic [AW:0]            valid_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [AW:0]      r_count;
  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_key;
  logic             r_found;
  logic [AW-1:0]    r_match;

  logic [DEPTH-1:0] w_wr_mask;
  logic [DEPTH-1:0] w_valid_nxt;
  logic [AW:0]      w_count_nxt;
  logic             w_hit;
  state_t           w_state_nxt;
  logic [AW-1:0]    w_idx_nxt;
  logic [WIDTH-1:0] w_key_nxt;
  logic             w_found_nxt;
  logic [AW-1:0]    w_match_nxt;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign entries_flat[gi*WIDTH +: WIDTH] = r_mem[gi];
    end
  endgenerate

  // clear wins over a same-cycle write: data lands, valid bit does not
  assign w_wr_mask   = wr_en ? (DEPTH'(1) << wr_addr) : '0;
  assign w_valid_nxt = clear ? '0 : (r_valid | w_wr_mask);

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count_nxt = w_count_nxt + (AW+1)'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_valid <= '0;
      r_count <= '0;
    end else begin
      if (wr_en) begin
        r_mem[wr_addr] <= wr_data;
      end
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign w_hit = r_valid[r_idx] && (scan_data == r_key);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_key   <= '0;
      r_found <= 1'b0;
      r_match <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_key   <= w_key_nxt;
      r_found <= w_found_nxt;
      r_match <= w_match_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_key_nxt   = r_key;
    w_found_nxt = r_found;
    w_match_nxt = r_match;
    busy        = 1'b0;
    done        = 1'b0;
    scan_select = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_key_nxt   = key;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy        = 1'b1;
        scan_select = r_idx;
        if (w_hit) begin
          w_found_nxt = 1'b1;
          w_match_nxt = r_idx;
          w_state_nxt = ST_DONE;
        end else if (r_idx == AW'(DEPTH - 1)) begin
          w_found_nxt = 1'b0;
          w_match_nxt = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign found       = r_found;
  assign match_index = r_match;
  assign valid_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_entry_search_bank.sv
// ============================================================================
//  Module      : tb_entry_search_bank
//  Description : Scoreboard bench for entry_search_bank with a behavioural mux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_entry_search_bank;

  logic          clock;
  logic          reset;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [12:0]   wr_data;
  logic          clear;
  logic [415:0]  entries_flat;
  logic [4:0]    scan_select;
  logic [12:0]   scan_data;
  logic          start;
  logic [12:0]   key;
  logic          busy;
  logic          done;
  logic          found;
  logic [4:0]    match_index;
  logic [5:0]    valid_count;

  typedef struct packed {
    logic       f;
    logic [4:0] idx;
  } res_t;

  res_t        sb_q[$];
  logic [12:0] m_mem [32];
  logic [31:0] m_valid;
  int          n_cmp;
  int          n_err;
  int          n_done;

  entry_search_bank dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .clear        (clear),
    .entries_flat (entries_flat),
    .scan_select  (scan_select),
    .scan_data    (scan_data),
    .start        (start),
    .key          (key),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .match_index  (match_index),
    .valid_count  (valid_count)
  );

  // Downstream 32:1 mux
  assign scan_data = entries_flat[int'(scan_select)*13 +: 13];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model_search(input logic [12:0] k);
    res_t r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (m_valid[i] && m_mem[i] == k) begin
        r.f   = 1'b1;
        r.idx = 5'(i);
        return r;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [12:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    m_mem[a]   = d;
    m_valid[a] = 1'b1;
  endtask

  task automatic do_start(input logic [12:0] k, input res_t exp);
    start = 1'b1;
    key   = k;
    sb_q.push_back(exp);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_timeout", 32'(seen), 32'd1);
    tick();
  endtask

  always @(negedge clock) begin
    if (done) begin
      res_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("found", 32'(found), 32'(e.f));
        chk("match_index", 32'(match_index), 32'(e.idx));
      end
    end
  end

  initial begin
    int   cnt;
    int   d0;
    res_t e;
    n_cmp = 0; n_err = 0; n_done = 0;
    m_valid = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clear = 1'b0; start = 1'b0; key = '0;
    tick(); tick();

    // Reset state
    @(negedge clock);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_match", 32'(match_index), 0);
    chk("rst_sel", 32'(scan_select), 0);
    chk("rst_vcnt", 32'(valid_count), 0);
    chk("rst_flat_zero", 32'(entries_flat == '0), 1);
    #1 reset = 1'b0;
    tick();

    // First hit at 5, duplicate at 9
    do_write(5'd5, 13'h0ABC);
    do_write(5'd9, 13'h0ABC);
    e.f = 1'b1; e.idx = 5'd5;
    chk("model_hit5", 32'(model_search(13'h0ABC)), 32'(e));
    do_start(13'h0ABC, model_search(13'h0ABC));
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("scan_sel_step", 32'(scan_select), 32'(k));
      chk("scan_busy", 32'(busy), 1);
      chk("scan_no_done", 32'(done), 0);
      tick();
    end
    @(negedge clock);
    chk("done_at_6", 32'(done), 1);
    chk("busy_in_done", 32'(busy), 1);
    tick();
    @(negedge clock);
    chk("idle_done_low", 32'(done), 0);
    chk("idle_busy_low", 32'(busy), 0);
    chk("vcnt_2", 32'(valid_count), 2);

    // Full miss
    #1;
    d0 = n_done;
    do_start(13'h1FFF, model_search(13'h1FFF));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy) break;
      cnt++;
    end
    chk("miss_busy_cycles", 32'(cnt), 33);
    chk("miss_sel_idle", 32'(scan_select), 0);
    chk("miss_one_done", 32'(n_done - d0), 1);
    #1;

    // Clear invalidates; invalid entry with equal data never matches
    do_write(5'd3, 13'h0000);
    clear = 1'b1; tick(); clear = 1'b0;
    m_valid = '0;
    @(negedge clock);
    chk("clr_vcnt", 32'(valid_count), 0);
    chk("clr_e3_data", 32'(entries_flat[3*13 +: 13]), 0);
    chk("clr_e5_data", 32'(entries_flat[5*13 +: 13]), 32'h0ABC);
    #1;
    do_start(13'h0000, model_search(13'h0000));
    wait_done(40);

    // Clear beats a same-cycle write, but the data is stored
    clear = 1'b1; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 13'h0055;
    tick();
    clear = 1'b0; wr_en = 1'b0;
    m_mem[7] = 13'h0055;
    @(negedge clock);
    chk("clrwr_vcnt", 32'(valid_count), 0);
    chk("clrwr_data", 32'(entries_flat[7*13 +: 13]), 32'h0055);
    #1;

    // Write ahead of the scan pointer; mid-scan start ignored
    m_mem[20] = 13'h0123; m_valid[20] = 1'b1;
    e = model_search(13'h0123);
    m_valid[20] = 1'b0;
    d0 = n_done;
    do_start(13'h0123, e);
    tick(); tick();
    start = 1'b1; key = 13'h0000; tick(); start = 1'b0;
    do_write(5'd20, 13'h0123);
    wait_done(40);
    chk("midscan_one_done", 32'(n_done - d0), 1);
    do_write(5'd20, 13'h0123);
    @(negedge clock);
    chk("rewrite_vcnt", 32'(valid_count), 1);
    #1;

    // Reset during SCAN at idx 10 aborts
    do_start(13'h0777, model_search(13'h0777));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy && scan_select == 5'd10) break;
      cnt++;
    end
    chk("reach_idx10", 32'(scan_select), 10);
    reset = 1'b1;
    d0 = n_done;
    @(posedge clock); #1;
    reset = 1'b0;
    m_valid = '0;
    sb_q.delete();
    @(negedge clock);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sel", 32'(scan_select), 0);
    chk("abort_vcnt", 32'(valid_count), 0);
    chk("abort_found", 32'(found), 0);
    for (int i = 0; i < 40; i++) @(negedge clock);
    chk("abort_no_done", 32'(n_done - d0), 0);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
